// File: rtl/decrypt_result_deser_pkg.sv
// rtl/decrypt_result_deser_pkg.sv - shared sizes and FSM encoding for the result deserializer
package decrypt_result_deser_pkg;

  localparam int N_BITS  = 536;
  localparam int WORD_W  = 32;
  localparam int N_WORDS = (N_BITS + WORD_W - 1) / WORD_W;
  localparam int ADDR_W  = $clog2(N_WORDS);
  localparam int CNT_W   = $clog2(N_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/decrypt_result_deser_bit_packer.sv
// rtl/decrypt_result_deser_bit_packer.sv - LSB-first serial-to-word packer
module decrypt_result_deser_bit_packer #(
  parameter int WORD_W = 32,
  localparam int IDX_W = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              din,
  output logic [WORD_W-1:0] word_next,
  output logic [IDX_W-1:0]  idx_next,
  output logic              word_done
);

  logic [WORD_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;

  // word_next already holds the incoming bit so the owner can register it on the same edge
  always_comb begin
    word_next = shift_reg;
    if (shift_en) word_next[bit_idx] = din;
    word_done = shift_en && (bit_idx == IDX_W'(WORD_W - 1));
    idx_next  = word_done ? '0 : bit_idx + {{(IDX_W-1){1'b0}}, shift_en};
  end

  // clearing after a full word keeps the upper bits of a later partial word zero
  always_ff @(posedge clk) begin
    if (!rst_b || clear || word_done) begin
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      shift_reg <= word_next;
      bit_idx   <= idx_next;
    end
  end

endmodule

// File: rtl/decrypt_result_deser.sv
// rtl/decrypt_result_deser.sv - launches the decrypt core and stores its serial result as RAM words
module decrypt_result_deser
  import decrypt_result_deser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  output logic              core_start,
  input  logic              din,
  input  logic              din_valid,
  input  logic              core_finish,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = $clog2(WORD_W);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bit_cnt, cnt_next;
  logic [ADDR_W-1:0]  word_addr;
  logic               finish_seen;
  logic               shift_en, word_done, clear_pk, at_end, leave, wr_en;
  logic [WORD_W-1:0]  word_next;
  logic [IDX_W-1:0]   idx_next;

  assign shift_en = (state == ST_COLLECT) && din_valid;
  assign cnt_next = bit_cnt + {{(CNT_W-1){1'b0}}, shift_en};
  assign at_end   = (cnt_next == CNT_W'(N_BITS));
  assign leave    = (state == ST_COLLECT) && (at_end || core_finish);
  // a partial word is written on the edge that leaves COLLECT, so FLUSH only waits for finish
  assign wr_en    = (shift_en && word_done) || (leave && (idx_next != '0));
  assign clear_pk = ((state == ST_IDLE) && start) || leave;

  decrypt_result_deser_bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk       (clk),
    .rst_b     (rst_b),
    .clear     (clear_pk),
    .shift_en  (shift_en),
    .din       (din),
    .word_next (word_next),
    .idx_next  (idx_next),
    .word_done (word_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_LAUNCH;
      ST_LAUNCH:  state_nxt = ST_COLLECT;
      ST_COLLECT: if (leave) state_nxt = ST_FLUSH;
      ST_FLUSH:   if (finish_seen || core_finish) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    core_start = (state == ST_LAUNCH);
    busy       = (state == ST_LAUNCH) || (state == ST_COLLECT) || (state == ST_FLUSH);
    done       = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      bit_cnt     <= '0;
      word_addr   <= '0;
      finish_seen <= 1'b0;
      err         <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
    end else begin
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= word_addr;
        mem_din   <= word_next;
        word_addr <= word_addr + ADDR_W'(1);
      end
      if ((state == ST_IDLE) && start) begin
        bit_cnt     <= '0;
        word_addr   <= '0;
        finish_seen <= 1'b0;
        err         <= 1'b0;
      end else begin
        bit_cnt <= cnt_next;
        if (((state == ST_COLLECT) || (state == ST_FLUSH)) && core_finish)
          finish_seen <= 1'b1;
        if ((state == ST_COLLECT) && core_finish && !at_end)
          err <= 1'b1;
        // bits arriving once the full result has been counted are dropped and flagged
        if (((state == ST_FLUSH) || (state == ST_DONE)) && din_valid &&
            (bit_cnt == CNT_W'(N_BITS)))
          err <= 1'b1;
      end
    end
  end

endmodule
